reg_file_master: RTL and testbench

- Bus initiator that drives the register file's exec/write/address/data_write interface and captures its data_read return.
- Accepts one read or write command at a time on a valid/ready request port.
- Issues a single-cycle exec pulse to the register file, then returns the result on a valid/ready response port.
- Sits between CPU/test sequencer logic and the register file; also keeps a count of completed transactions.

---
 rtl/reg_file_master.sv | 128 ++++++++++++
 tb/tb_reg_file_master.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_master.sv
// Register-file bus initiator: one read/write command at a time, single-cycle exec strobe, counted responses.
// Optional REG_FILE_MASTER_ADDR_CHECK_EN rejects req_addr >= NUM_REGS with rsp_err instead of issuing it.
module reg_file_master #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_write,
    output logic              write,
    output logic              exec,
    input  logic [DATA_W-1:0] data_read,
    output logic [CNT_W-1:0]  txn_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state, state_n;
    logic              exec_n, write_n, rsp_valid_n, rsp_err_n;
    logic [ADDR_W-1:0] address_n;
    logic [DATA_W-1:0] data_write_n, rsp_rdata_n;
    logic [CNT_W-1:0]  txn_count_n;
    logic              addr_bad;

    assign req_ready = (state == IDLE);

`ifdef REG_FILE_MASTER_ADDR_CHECK_EN
    assign addr_bad = (req_addr >= ADDR_W'(NUM_REGS));
`else
    assign addr_bad = 1'b0;
`endif

    // State register and registered bus/response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            exec       <= 1'b0;
            write      <= 1'b0;
            address    <= '0;
            data_write <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            txn_count  <= '0;
        end else begin
            state      <= state_n;
            exec       <= exec_n;
            write      <= write_n;
            address    <= address_n;
            data_write <= data_write_n;
            rsp_valid  <= rsp_valid_n;
            rsp_rdata  <= rsp_rdata_n;
            rsp_err    <= rsp_err_n;
            txn_count  <= txn_count_n;
        end
    end

    // Next state and next values of every registered output
    always_comb begin
        state_n      = state;
        exec_n       = 1'b0;
        write_n      = 1'b0;
        address_n    = address;
        data_write_n = data_write;
        rsp_valid_n  = 1'b0;
        rsp_rdata_n  = rsp_rdata;
        rsp_err_n    = rsp_err;
        txn_count_n  = txn_count;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (addr_bad) begin
                        // Rejected request: straight to response, bus untouched
                        state_n     = RESP;
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b1;
                        rsp_rdata_n = '0;
                    end else begin
                        state_n      = ISSUE;
                        exec_n       = 1'b1;
                        write_n      = req_write;
                        address_n    = req_addr;
                        data_write_n = req_wdata;
                        rsp_err_n    = 1'b0;
                    end
                end
            end
            ISSUE: begin
                if (write) begin
                    state_n     = RESP;
                    rsp_valid_n = 1'b1;
                    rsp_rdata_n = '0;
                end else begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                // Register file returns read data the cycle after exec
                state_n     = RESP;
                rsp_valid_n = 1'b1;
                rsp_rdata_n = data_read;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n     = IDLE;
                    txn_count_n = txn_count + CNT_W'(1);
                end else begin
                    rsp_valid_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_file_master.sv
// Randomized self-checking bench for reg_file_master with a behavioural register-file model and scoreboard.
// Honours REG_FILE_MASTER_ADDR_CHECK_EN in its expectations; counter width is reduced to 4 to exercise wrap.
module tb_reg_file_master;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned CNT_W    = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid, req_ready, req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_write, data_read;
    logic              write, exec;
    logic [CNT_W-1:0]  txn_count;

    int n_checks = 0;
    int n_fail   = 0;

    reg_file_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .address(address), .data_write(data_write), .write(write), .exec(exec),
        .data_read(data_read), .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return 32'hA5A5_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    // Environment register file: write on exec, read data one cycle after exec
    logic [31:0] rf_mem [0:NUM_REGS-1];
    logic        rf_load;
    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < int'(NUM_REGS); i++) rf_mem[i] <= init_val(i);
        end else if (exec) begin
            if (write) begin
                if (address < ADDR_W'(NUM_REGS)) rf_mem[address[4:0]] <= data_write;
            end else begin
                data_read <= (address < ADDR_W'(NUM_REGS)) ? rf_mem[address[4:0]] : 32'h0;
            end
        end
    end

    // Bus monitor: exec pulses and their payload, plus exec/rsp_valid overlap
    int          exec_total = 0;
    int          overlap    = 0;
    logic [31:0] mon_addr, mon_wdata;
    logic        mon_write;
    always @(negedge clk) begin
        if (exec) begin
            exec_total = exec_total + 1;
            mon_addr   = address;
            mon_wdata  = data_write;
            mon_write  = write;
        end
        if (exec && rsp_valid) overlap = overlap + 1;
    end

    // Reference model state
    logic [31:0] exp_mem [0:NUM_REGS-1];
    int          exp_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd, input int bp);
        bit          err, bad_rdy, bad_stab;
        int          lat, exec0, exp_lat;
        logic [31:0] exp_rd, rd0;
`ifdef REG_FILE_MASTER_ADDR_CHECK_EN
        err = (addr >= 32'(NUM_REGS));
`else
        err = 1'b0;
`endif
        exp_rd  = (err || wr || addr >= 32'(NUM_REGS)) ? 32'h0 : exp_mem[addr[4:0]];
        exp_lat = err ? 1 : (wr ? 2 : 3);
        check("req_ready_idle", 64'(req_ready), 64'(1));
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        rsp_ready = (bp == 0);
        exec0 = exec_total;
        @(posedge clk); #1;
        // Garbage on the request port while busy must be ignored
        req_valid = 1'b1; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        lat = 0; bad_rdy = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk); #1;
            if (req_ready) bad_rdy = 1'b1;
            if (rsp_valid) begin lat = k; break; end
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("req_ready_busy", 64'(bad_rdy), 64'(0));
        if (lat == 0) begin
            req_valid = 1'b0;
            return;
        end
        check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
        check("rsp_err", 64'(rsp_err), 64'(err));
        rd0 = rsp_rdata; bad_stab = 1'b0;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk); #1;
            if (!rsp_valid || rsp_rdata !== rd0 || req_ready) bad_stab = 1'b1;
        end
        if (bp > 0) check("backpressure_hold", 64'(bad_stab), 64'(0));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_ready = 1'($urandom);
        if (wr && !err && addr < 32'(NUM_REGS)) exp_mem[addr[4:0]] = wd;
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        check("rsp_done", 64'({rsp_valid, req_ready}), 64'(2'b01));
        check("txn_count", 64'(txn_count), 64'(exp_cnt));
        check("exec_pulses", 64'(exec_total - exec0), 64'(err ? 0 : 1));
        if (!err) begin
            check("exec_write", 64'(mon_write), 64'(wr));
            check("exec_addr", 64'(mon_addr), 64'(addr));
            if (wr) check("exec_wdata", 64'(mon_wdata), 64'(wd));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, 64'({exec, write, rsp_valid, rsp_err, txn_count}), 64'(0));
        check({tag, "_bus"}, {address, data_write}, 64'(0));
        check({tag, "_rdata"}, 64'(rsp_rdata), 64'(0));
    endtask

    initial begin
        bit          seen;
        int          e0;
        rst_n = 1'b0; rf_load = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        for (int i = 0; i < int'(NUM_REGS); i++) exp_mem[i] = init_val(i);
        repeat (2) @(posedge clk);
        #1 rf_load = 1'b0;
        check_reset_outputs("reset_state");
        check("reset_req_ready", 64'(req_ready), 64'(1));
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;

        // Directed: write, read-back, backpressured read, out-of-range read
        do_txn(1'b1, 32'd5, 32'hDEAD_BEEF, 0);
        do_txn(1'b0, 32'd5, 32'h0, 0);
        do_txn(1'b0, 32'd5, 32'h0, 5);
        do_txn(1'b0, 32'd32, 32'h0, 0);

        // Reset asserted during the ISSUE cycle abandons the transaction
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd7; req_wdata = 32'h1234_5678; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("issue_exec", 64'(exec), 64'(1));
        rst_n = 1'b0; #1;
        exp_cnt = 0;
        check_reset_outputs("mid_reset");
        @(negedge clk); rst_n = 1'b1;
        e0 = exec_total; seen = 1'b0;
        repeat (6) begin
            @(negedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("no_rsp_after_reset", 64'({seen, 1'b0}) + 64'(exec_total - e0), 64'(0));
        do_txn(1'b0, 32'd7, 32'h0, 0);

        // Randomized traffic; long enough to wrap the 4-bit counter
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            #1;
            do_txn(1'($urandom), 32'($urandom_range(0, 35)), $urandom, int'($urandom_range(0, 3)));
        end

        check("exec_rsp_overlap", 64'(overlap), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
